hand_shake_rx: RTL

// - Receiver end of the four-phase full-handshake CDC link; pairs with the Tx-side handshake sender.
// - Synchronises the sender's ready level into the Rx clock domain and captures the sender's data word.
// - Returns an ack level to the sender and presents each word downstream on a valid/ready interface.
// - Sits in the Rx clock domain; the sender runs on an unrelated clock.

---
 rtl/hand_shake_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hand_shake_rx.sv
// Receiver end of the four-phase ready/ack CDC link, with a valid/ready downstream port.
// Build option HSK_RX_SKID_EN: 2-entry output FIFO instead of a single output register.
//
// state    | meaning
// IDLE     | ack low, waiting for synchronised ready with buffer space
// ACK_HIGH | word captured, ack held high until synchronised ready drops
module hand_shake_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  iRxClk,
  input  logic                  iRstnRx,
  input  logic                  iTxRdy,
  input  logic [DATA_WIDTH-1:0] iTxData,
  input  logic                  iDataReady,
  output logic                  oRxAck,
  output logic                  oDataValid,
  output logic [DATA_WIDTH-1:0] oData,
  output logic [CNT_WIDTH-1:0]  oWordCnt
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ACK_HIGH = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 rdy_meta_q, rdy_sync_q;
  logic                 ack_q, ack_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 has_space;
  logic                 capture;
  logic                 drain;

  // Only the ready level crosses domains; data is sampled once ready is seen synchronised.
  always_ff @(posedge iRxClk or negedge iRstnRx) begin
    if (!iRstnRx) begin
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      rdy_meta_q <= iTxRdy;
      rdy_sync_q <= rdy_meta_q;
    end
  end

  always_ff @(posedge iRxClk or negedge iRstnRx) begin
    if (!iRstnRx) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rdy_sync_q && has_space) state_d = ST_ACK_HIGH;
      ST_ACK_HIGH: if (!rdy_sync_q) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture = (state_q == ST_IDLE) && rdy_sync_q && has_space;
    ack_d   = (state_d == ST_ACK_HIGH);
    cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, capture};
  end

  assign drain = oDataValid && iDataReady;

`ifdef HSK_RX_SKID_EN
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  // Space is judged on the pre-drain occupancy, so a full FIFO never takes a word and pops in one cycle.
  assign has_space = (count_q != 2'd2);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (capture) begin
      mem_d[wr_ptr_q] = iTxData;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (drain) rd_ptr_d = ~rd_ptr_q;
    case ({capture, drain})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iRxClk or negedge iRstnRx) begin
    if (!iRstnRx) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign oDataValid = (count_q != 2'd0);
  assign oData      = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  assign has_space = !valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (capture) begin
      data_d  = iTxData;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iRxClk or negedge iRstnRx) begin
    if (!iRstnRx) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oDataValid = valid_q;
  assign oData      = data_q;
`endif

  assign oRxAck   = ack_q;
  assign oWordCnt = cnt_q;

endmodule
